// File: rtl/constraint_batch_checker_if.sv
// Beat streaming bundle for constraint_batch_checker: operand input side and result output side.
interface constraint_batch_checker_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_CH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH*NUM_CH-1:0]   in_a;
  logic [WIDTH*NUM_CH-1:0]   in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_CH-1:0]         out_mask;
  logic                      out_all;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_mask, out_all
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_mask, out_all
  );
endinterface

// File: rtl/constraint_batch_checker.sv
// Evaluates NUM_CH per-channel operand relations per beat and counts passing beats over a batch.
// Optional CONSTRAINT_STICKY_EN adds a per-channel sticky failure output.
module constraint_batch_checker #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        batch_len,
  input  logic [2*NUM_CH-1:0]     mode,
  constraint_batch_checker_if.slave bus,
  output logic                    done,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        beat_cnt
`ifdef CONSTRAINT_STICKY_EN
  ,
  output logic [NUM_CH-1:0]       sticky_fail
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      len_q;
  logic [2*NUM_CH-1:0]   mode_q;
  logic                  out_valid_q;
  logic [NUM_CH-1:0]     out_mask_q;
  logic                  out_all_q;
  logic                  done_q;
  logic [CNT_W-1:0]      pass_cnt_q;
  logic [CNT_W-1:0]      beat_cnt_q;

  logic [NUM_CH-1:0]     mask_c;
  logic [WIDTH-1:0]      a_v;
  logic [WIDTH-1:0]      b_v;
  logic                  in_ready_c;
  logic                  accept_c;
  logic                  last_c;

  // Per-channel relation on the beat currently presented.
  always_comb begin
    mask_c = '0;
    a_v    = '0;
    b_v    = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      a_v = bus.in_a[c*WIDTH +: WIDTH];
      b_v = bus.in_b[c*WIDTH +: WIDTH];
      case (mode_q[2*c +: 2])
        2'd0:    mask_c[c] = |(a_v & b_v);
        2'd1:    mask_c[c] = ~|(a_v & b_v);
        2'd2:    mask_c[c] = ((a_v & ~b_v) == '0);
        default: mask_c[c] = (a_v == b_v);
      endcase
    end
  end

  // Accept only while beats remain and the output slot is free or draining this cycle.
  assign in_ready_c = (state_q == RUN) && (beat_cnt_q < len_q) && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign last_c     = (beat_cnt_q == len_q) && (!out_valid_q || bus.out_ready);

`ifdef CONSTRAINT_STICKY_EN
  logic [NUM_CH-1:0] sticky_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (state_q == IDLE && start) begin
      sticky_q <= '0;
    end else if (accept_c) begin
      sticky_q <= sticky_q | ~mask_c;
    end
  end
  assign sticky_fail = sticky_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_all_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_cnt_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pass_cnt_q <= '0;
            beat_cnt_q <= '0;
            if (batch_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              len_q   <= batch_len;
              mode_q  <= mode;
            end
          end
        end
        RUN: begin
          if (accept_c) begin
            out_valid_q <= 1'b1;
            out_mask_q  <= mask_c;
            out_all_q   <= &mask_c;
            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if ((&mask_c) && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (last_c) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_all   = out_all_q;
  assign done          = done_q;
  assign pass_cnt      = pass_cnt_q;
  assign beat_cnt      = beat_cnt_q;

endmodule
